// File: rtl/fir_pkg.sv
// fir_pkg: shared constants for the 7-tap systolic FIR slice.
// Coefficients are the array's fixed tap weights; COEF_SUM is the DC gain.
package fir_pkg;

   localparam int FIR_DATA_W     = 32'sd32;
   localparam int FIR_FIFO_DEPTH = 32'sd8;
   localparam int FIR_TAPS       = 32'sd7;

   localparam int W0 = 32'sd4;
   localparam int W1 = 32'sd18;
   localparam int W2 = 32'sd47;
   localparam int W3 = 32'sd62;
   localparam int W4 = 32'sd47;
   localparam int W5 = 32'sd18;
   localparam int W6 = 32'sd4;

   localparam int COEF_SUM = W0 + W1 + W2 + W3 + W4 + W5 + W6;

   // Tap weight lookup by index; out-of-range taps weigh zero.
   function automatic int fir_coef(input int k);
      case (k)
         32'sd0:  return W0;
         32'sd1:  return W1;
         32'sd2:  return W2;
         32'sd3:  return W3;
         32'sd4:  return W4;
         32'sd5:  return W5;
         32'sd6:  return W6;
         default: return 32'sd0;
      endcase
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through buffer with occupancy count.
// A push into a full FIFO is refused even when a pop frees a slot in the
// same cycle; flush empties the buffer and overrides any transfer.
module sync_fifo
   import fir_pkg::*;
#(
   parameter int  DATA_W = FIR_DATA_W,
   parameter int  DEPTH  = FIR_FIFO_DEPTH,
   localparam int AW     = $clog2(DEPTH)
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              push,
   input  logic [DATA_W-1:0] wdata,
   input  logic              pop,
   output logic [DATA_W-1:0] rdata,
   output logic              full,
   output logic              empty,
   output logic [AW:0]       level
);

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [AW-1:0]     wr_ptr_r;
   logic [AW-1:0]     rd_ptr_r;
   logic [AW:0]       level_r;
   logic              wr_en_s;
   logic              rd_en_s;

   assign full    = (level_r == FULL_LVL);
   assign empty   = (level_r == {(AW+1){1'b0}});
   assign level   = level_r;
   assign rdata   = mem_r[rd_ptr_r];
   assign wr_en_s = push & ~full & ~flush;
   assign rd_en_s = pop & ~empty & ~flush;

   // Sample storage; contents need no reset because occupancy gates every read.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally at a power-of-2 depth.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         level_r  <= {(AW+1){1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         level_r  <= {(AW+1){1'b0}};
      end else begin
         if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (rd_en_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({wr_en_s, rd_en_s})
            2'b10:   level_r <= level_r + (AW+1)'(1);
            2'b01:   level_r <= level_r - (AW+1)'(1);
            default: level_r <= level_r;
         endcase
      end
   end

endmodule

// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder: buffers the input stream and meters one sample per
// SPACING-cycle slot into the counter-flowing systolic FIR array. Each
// injected sample carries a tag that travels alongside the array latency so
// only genuine filter responses are presented downstream.
module fir_sample_feeder
   import fir_pkg::*;
#(
   parameter int  DATA_W         = FIR_DATA_W,
   parameter int  FIFO_DEPTH     = FIR_FIFO_DEPTH,
   parameter int  SPACING        = 2,
   parameter int  FILTER_LATENCY = 1,
   localparam int LVL_W          = $clog2(FIFO_DEPTH) + 1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic              flush,
   output logic [DATA_W-1:0] original,
   input  logic [DATA_W-1:0] filtered,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   output logic [LVL_W-1:0]  level
);

   localparam int              PH_W    = (SPACING > 1) ? $clog2(SPACING) : 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(SPACING - 1);

   logic [PH_W-1:0]         phase_r;
   // tag_r[0] is loaded on the injection edge, alongside original; the
   // extra stage covers the cycle the array needs to see the new original
   // before its registered result appears on filtered.
   logic [FILTER_LATENCY:0] tag_r;
   logic [DATA_W-1:0]       head_s;
   logic                    empty_s;
   logic                    full_s;
   logic                    slot_s;
   logic                    pop_s;
   logic                    push_s;

   assign slot_s  = (phase_r == {PH_W{1'b0}});
   assign pop_s   = slot_s & ~empty_s & ~flush;
   assign push_s  = s_valid & ~full_s;
   assign s_ready = ~full_s;

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push_s),
      .wdata (s_data),
      .pop   (pop_s),
      .rdata (head_s),
      .full  (full_s),
      .empty (empty_s),
      .level (level)
   );

   // Free-running slot phase; never stalls so the systolic spacing holds.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_r <= {PH_W{1'b0}};
      end else if (flush) begin
         phase_r <= {PH_W{1'b0}};
      end else if (phase_r == PH_LAST) begin
         phase_r <= {PH_W{1'b0}};
      end else begin
         phase_r <= phase_r + PH_W'(1);
      end
   end

   // Slot injection: head sample on a populated phase-0 slot, zero otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         original <= {DATA_W{1'b0}};
      end else if (flush) begin
         original <= {DATA_W{1'b0}};
      end else if (pop_s) begin
         original <= head_s;
      end else begin
         original <= {DATA_W{1'b0}};
      end
   end

   // Tag line and output capture: take filtered when a tag reaches the end.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tag_r   <= {(FILTER_LATENCY+1){1'b0}};
         m_data  <= {DATA_W{1'b0}};
         m_valid <= 1'b0;
      end else if (flush) begin
         tag_r   <= {(FILTER_LATENCY+1){1'b0}};
         m_valid <= 1'b0;
      end else begin
         tag_r <= {tag_r[FILTER_LATENCY-1:0], pop_s};
         if (tag_r[FILTER_LATENCY]) begin
            m_data  <= filtered;
            m_valid <= 1'b1;
         end else begin
            m_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// tb_fir_sample_feeder: drives the feeder into a behavioural 7-tap array and
// checks every cycle against a queue-based reference of the feeder rules.
module tb_fir_sample_feeder;
   import fir_pkg::*;

   localparam int DW    = 32;
   localparam int DEPTH = 8;
   localparam int SPC   = 2;
   localparam int LAT   = 1;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic          flush = 1'b0;
   logic [DW-1:0] original;
   logic [DW-1:0] filtered = '0;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic [LW-1:0] level;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   fir_sample_feeder #(
      .DATA_W(DW), .FIFO_DEPTH(DEPTH), .SPACING(SPC), .FILTER_LATENCY(LAT)
   ) dut (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .flush(flush), .original(original), .filtered(filtered),
      .m_data(m_data), .m_valid(m_valid), .level(level)
   );

   function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at time %0t", nm, $signed(act), $signed(exp), $time);
      end
   endfunction

   // Behavioural systolic array: y(t) = sum_k w_k * original(t-2k), one cycle late
   int fhist [0:11];
   initial for (int j = 0; j < 12; j++) fhist[j] = 0;
   always @(posedge clk) begin
      int acc;
      acc = fir_coef(0) * int'(original);
      for (int k = 1; k < 7; k++) acc += fir_coef(k) * fhist[2*k-1];
      filtered <= acc;
      for (int j = 11; j > 0; j--) fhist[j] <= fhist[j-1];
      fhist[0] <= int'(original);
   end

   // Reference model of the feeder: a queue, a slot counter, and a list of due outputs
   int mq[$];
   int pend_due[$];
   int pend_val[$];
   int mhist [0:12];
   int mphase = 0;
   int morig  = 0;
   int mdata  = 0;
   bit mvalid = 1'b0;
   int cyc    = 0;
   initial for (int j = 0; j < 13; j++) mhist[j] = 0;

   function automatic void model_reset();
      mq.delete(); pend_due.delete(); pend_val.delete();
      mphase = 0; morig = 0; mdata = 0; mvalid = 1'b0;
   endfunction

   // Model step on every clock edge using the inputs as presented before the edge
   always @(posedge clk) begin
      int sz;
      int acc;
      bit popd;
      popd = 1'b0;
      if (!rst) begin
         model_reset();
      end else if (flush) begin
         mq.delete(); pend_due.delete(); pend_val.delete();
         mphase = 0; morig = 0; mvalid = 1'b0;
      end else begin
         sz = mq.size();
         if (mphase == 0 && sz > 0) begin
            morig = mq.pop_front();
            popd  = 1'b1;
         end else begin
            morig = 0;
         end
         if (s_valid && sz != DEPTH) mq.push_back(int'(s_data));
         mphase = (mphase + 1) % SPC;
         mvalid = 1'b0;
         if (pend_due.size() > 0 && pend_due[0] == cyc) begin
            mvalid = 1'b1;
            mdata  = pend_val.pop_front();
            void'(pend_due.pop_front());
         end
      end
      for (int j = 12; j > 0; j--) mhist[j] = mhist[j-1];
      mhist[0] = morig;
      if (popd) begin
         acc = 0;
         for (int k = 0; k < 7; k++) acc += fir_coef(k) * mhist[2*k];
         pend_due.push_back(cyc + 1 + LAT);
         pend_val.push_back(acc);
      end
      cyc++;
   end

   // Single compare process: every output against the model, every cycle
   always @(negedge clk) begin
      check("original", original, morig);
      check("m_valid", {31'd0, m_valid}, {31'd0, mvalid});
      check("m_data", m_data, mdata);
      check("level", {{(32-LW){1'b0}}, level}, mq.size());
      check("s_ready", {31'd0, s_ready}, (mq.size() != DEPTH) ? 32'd1 : 32'd0);
   end

   // Collectors for the literal end-to-end checks
   int outq[$];
   int origq[$];
   int mv_cnt = 0;
   always @(negedge clk) begin
      if (m_valid === 1'b1) begin
         outq.push_back(int'(m_data));
         mv_cnt++;
      end
      if (original !== '0) origq.push_back(int'(original));
   end

   int imp_exp [10] = '{4, 18, 47, 62, 47, 18, 4, 0, 0, 0};
   int stp_exp [12] = '{4, 22, 69, 131, 178, 196, 200, 200, 200, 200, 200, 200};

   task automatic send(input int v, input int gap);
      bit r;
      int t;
      r = 1'b0; t = 0;
      s_valid = 1'b1; s_data = v;
      while (!r && t < 100) begin
         r = s_ready;
         @(negedge clk);
         t++;
      end
      check("send_accepted", {31'd0, r}, 32'd1);
      s_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((mq.size() != 0 || pend_due.size() != 0) && t < 400) begin
         @(negedge clk);
         t++;
      end
      check("drain_done", (t < 400) ? 32'd1 : 32'd0, 32'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic run_impulse(input string nm);
      outq.delete();
      repeat (20) @(negedge clk);
      send(1, 0);
      for (int i = 0; i < 9; i++) send(0, 0);
      drain();
      check({nm, "_count"}, outq.size(), 10);
      for (int i = 0; i < 10 && i < outq.size(); i++) check({nm, "_y"}, outq[i], imp_exp[i]);
   endtask

   initial begin
      int acc_cnt;
      int drop_at;
      int mv0;
      int t;
      bit r;

      repeat (3) @(negedge clk);
      check("reset_original", original, 32'd0);
      check("reset_m_valid", {31'd0, m_valid}, 32'd0);
      check("reset_level", {{(32-LW){1'b0}}, level}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("ready_after_reset", {31'd0, s_ready}, 32'd1);

      // 1: impulse response
      run_impulse("impulse");

      // 2: step response settles at the DC gain
      outq.delete();
      repeat (20) @(negedge clk);
      for (int i = 0; i < 12; i++) send(1, 0);
      drain();
      check("step_count", outq.size(), 12);
      for (int i = 0; i < 12 && i < outq.size(); i++) check("step_y", outq[i], stp_exp[i]);
      if (outq.size() > 0) check("step_dc_gain", outq[outq.size()-1], COEF_SUM);

      // 3: back-to-back source; phase aligned by a flush so the first push lands on phase 1
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      @(negedge clk);
      origq.delete();
      mv0 = mv_cnt;
      acc_cnt = 0; drop_at = -1;
      s_valid = 1'b1; s_data = 100;
      for (int i = 0; i < 200 && acc_cnt < 20; i++) begin
         r = s_ready;
         @(negedge clk);
         if (r) begin
            acc_cnt++;
            s_data = 100 + acc_cnt;
         end else if (drop_at < 0) begin
            drop_at = acc_cnt;
         end
      end
      s_valid = 1'b0;
      drain();
      check("b2b_first_drop", drop_at, 15);
      check("b2b_outputs", mv_cnt - mv0, 20);
      check("b2b_injected", origq.size(), 20);
      for (int i = 0; i < 20 && i < origq.size(); i++) check("b2b_order", origq[i], 100 + i);

      // 4: starved source, one sample every five cycles
      origq.delete();
      mv0 = mv_cnt;
      for (int i = 0; i < 8; i++) send(int'($urandom_range(1, 500)), 4);
      drain();
      check("starved_outputs", mv_cnt - mv0, 8);
      check("starved_injected", origq.size(), 8);

      // 5: flush with five entries buffered and tags in flight
      s_valid = 1'b1;
      t = 0;
      while (level != LW'(5) && t < 40) begin
         s_data = int'($urandom_range(1, 900));
         @(negedge clk);
         t++;
      end
      check("flush_setup_level", {{(32-LW){1'b0}}, level}, 32'd5);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      s_valid = 1'b0;
      check("flush_level", {{(32-LW){1'b0}}, level}, 32'd0);
      check("flush_m_valid", {31'd0, m_valid}, 32'd0);
      mv0 = mv_cnt;
      repeat (6) @(negedge clk);
      check("flush_quiet", mv_cnt - mv0, 0);
      send(7, 0);
      drain();
      check("flush_recover", mv_cnt - mv0, 1);

      // Randomized traffic with occasional flushes
      for (int i = 0; i < 1500; i++) begin
         s_valid = ($urandom_range(0, 3) != 0);
         s_data  = int'($urandom_range(0, 2000)) - 1000;
         flush   = ($urandom_range(0, 49) == 0);
         @(negedge clk);
      end
      s_valid = 1'b0;
      flush = 1'b0;
      drain();

      // 6: asynchronous reset mid-stream, then the impulse must still come out clean
      s_valid = 1'b1;
      for (int i = 0; i < 9; i++) begin
         s_data = int'($urandom_range(1, 900));
         @(negedge clk);
      end
      @(posedge clk);
      #3;
      rst = 1'b0;
      model_reset();
      #1;
      check("async_rst_original", original, 32'd0);
      check("async_rst_m_valid", {31'd0, m_valid}, 32'd0);
      check("async_rst_m_data", m_data, 32'd0);
      check("async_rst_level", {{(32-LW){1'b0}}, level}, 32'd0);
      s_valid = 1'b0;
      #9;
      rst = 1'b1;
      @(negedge clk);
      run_impulse("post_reset_impulse");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
